// File: rtl/mips_cpu_top.sv
// mips_cpu_top: multicycle MIPS-I subset core fetching big-endian code byte-wise from flash, with on-chip data RAM.
// Define MIPS_HEX_DISPLAY_EN to show the debug register on HEX7..HEX0; otherwise all segments stay dark.
module mips_cpu_top #(
    parameter int FL_WAIT    = 4,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic [8:0]  LEDG,
    output logic [17:0] LEDR,
    output logic [11:0] DRAM_ADDR,
    output logic        DRAM_BA_0,
    output logic        DRAM_BA_1,
    output logic        DRAM_CS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_WE_N,
    output logic        DRAM_CKE,
    output logic        DRAM_CLK,
    output logic        DRAM_LDQM,
    output logic        DRAM_UDQM,
    inout  wire  [15:0] DRAM_DQ,
    output logic [21:0] FL_ADDR,
    inout  wire  [7:0]  FL_DQ,
    output logic        FL_CE_N,
    output logic        FL_OE_N,
    output logic        FL_WE_N,
    output logic        FL_RST_N,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N
);
    localparam int AW = $clog2(DMEM_WORDS);
    localparam int WW = (FL_WAIT > 1) ? $clog2(FL_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(FL_WAIT - 1);

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_JUMP, K_ILL} kind_t;

    logic          rst_n;
    state_t        state_q;
    logic [31:0]   pc_q, npc_q, ir_q, addr_q, wb_q, debug_q, ram_rd_q;
    logic [4:0]    dst_q;
    logic          wb_ram_q;
    logic [WW-1:0] wait_q;
    logic [1:0]    byte_q;
    logic [21:0]   fl_addr_q;
    logic [31:0]   gpr_q [32];
    logic [31:0]   ram_q [DMEM_WORDS];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_v, rt_v, simm, zimm, br_tgt, j_tgt, link_addr;
    kind_t       ex_kind;
    logic [31:0] ex_res, ex_tgt;
    logic [4:0]  ex_dst;
    logic        ex_taken, ex_link;
    logic        fl_last, is_store, mem_flash, mem_ram, mem_dbg, mem_sw, ram_we;
    logic [31:0] io_rd;
    logic        unused_ok;

    assign rst_n     = KEY[0];
    assign op        = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign shamt     = ir_q[10:6];
    assign funct     = ir_q[5:0];
    assign rs_v      = gpr_q[rs];
    assign rt_v      = gpr_q[rt];
    assign simm      = {{16{ir_q[15]}}, ir_q[15:0]};
    assign zimm      = {16'h0000, ir_q[15:0]};
    assign br_tgt    = pc_q + 32'd4 + {simm[29:0], 2'b00};
    assign j_tgt     = {npc_q[31:28], ir_q[25:0], 2'b00};
    assign link_addr = pc_q + 32'd8;

    always_comb begin
        ex_kind  = K_ILL;
        ex_res   = '0;
        ex_dst   = rt;
        ex_taken = 1'b0;
        ex_tgt   = br_tgt;
        ex_link  = 1'b0;
        case (op)
            6'h00: begin
                ex_kind = K_ALU;
                ex_dst  = rd;
                case (funct)
                    6'h00: ex_res = rt_v << shamt;
                    6'h02: ex_res = rt_v >> shamt;
                    6'h03: ex_res = $signed(rt_v) >>> shamt;
                    6'h04: ex_res = rt_v << rs_v[4:0];
                    6'h06: ex_res = rt_v >> rs_v[4:0];
                    6'h07: ex_res = $signed(rt_v) >>> rs_v[4:0];
                    6'h08: begin ex_kind = K_JUMP; ex_taken = 1'b1; ex_tgt = rs_v; end
                    6'h09: begin
                        ex_kind = K_JUMP; ex_taken = 1'b1; ex_tgt = rs_v;
                        ex_link = 1'b1; ex_res = link_addr;
                    end
                    6'h21: ex_res = rs_v + rt_v;
                    6'h23: ex_res = rs_v - rt_v;
                    6'h24: ex_res = rs_v & rt_v;
                    6'h25: ex_res = rs_v | rt_v;
                    6'h26: ex_res = rs_v ^ rt_v;
                    6'h27: ex_res = ~(rs_v | rt_v);
                    6'h2a: ex_res = {31'd0, $signed(rs_v) < $signed(rt_v)};
                    6'h2b: ex_res = {31'd0, rs_v < rt_v};
                    default: ex_kind = K_ILL;
                endcase
            end
            6'h02: begin ex_kind = K_JUMP; ex_taken = 1'b1; ex_tgt = j_tgt; end
            6'h03: begin
                ex_kind = K_JUMP; ex_taken = 1'b1; ex_tgt = j_tgt;
                ex_link = 1'b1; ex_dst = 5'd31; ex_res = link_addr;
            end
            6'h04: begin ex_kind = K_JUMP; ex_taken = (rs_v == rt_v); end
            6'h05: begin ex_kind = K_JUMP; ex_taken = (rs_v != rt_v); end
            6'h06: begin ex_kind = K_JUMP; ex_taken = ($signed(rs_v) <= 0); end
            6'h07: begin ex_kind = K_JUMP; ex_taken = ($signed(rs_v) > 0); end
            6'h09: begin ex_kind = K_ALU; ex_res = rs_v + simm; end
            6'h0a: begin ex_kind = K_ALU; ex_res = {31'd0, $signed(rs_v) < $signed(simm)}; end
            6'h0b: begin ex_kind = K_ALU; ex_res = {31'd0, rs_v < simm}; end
            6'h0c: begin ex_kind = K_ALU; ex_res = rs_v & zimm; end
            6'h0d: begin ex_kind = K_ALU; ex_res = rs_v | zimm; end
            6'h0e: begin ex_kind = K_ALU; ex_res = rs_v ^ zimm; end
            6'h0f: begin ex_kind = K_ALU; ex_res = {ir_q[15:0], 16'h0000}; end
            6'h23: begin ex_kind = K_LOAD;  ex_res = rs_v + simm; end
            6'h2b: begin ex_kind = K_STORE; ex_res = rs_v + simm; end
            default: ex_kind = K_ILL;
        endcase
    end

    // lw (0x23) and sw (0x2B) differ only in opcode bit 3
    assign is_store  = ir_q[29];
    assign fl_last   = (wait_q == WAIT_LAST);
    assign mem_flash = (addr_q[31:28] == 4'h0);
    assign mem_ram   = (addr_q[31:28] == 4'h1);
    assign mem_dbg   = (addr_q[31:2] == 30'h3FFF_C000);
    assign mem_sw    = (addr_q[31:2] == 30'h3FFF_C001);
    assign io_rd     = mem_dbg ? debug_q : (mem_sw ? {14'd0, SW} : 32'd0);
    assign ram_we    = (state_q == S_MEM) && is_store && mem_ram;

    always_ff @(posedge CLOCK_50) begin
        if (ram_we) ram_q[addr_q[AW+1:2]] <= rt_v;
        ram_rd_q <= ram_q[addr_q[AW+1:2]];
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            npc_q     <= 32'd4;
            ir_q      <= '0;
            addr_q    <= '0;
            wb_q      <= '0;
            wb_ram_q  <= 1'b0;
            dst_q     <= '0;
            debug_q   <= '0;
            wait_q    <= '0;
            byte_q    <= '0;
            fl_addr_q <= '0;
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (fl_last) begin
                        wait_q <= '0;
                        ir_q   <= {ir_q[23:0], FL_DQ};
                        if (byte_q == 2'd3) begin
                            byte_q  <= '0;
                            state_q <= S_EXEC;
                        end else begin
                            byte_q    <= byte_q + 2'd1;
                            fl_addr_q <= fl_addr_q + 22'd1;
                        end
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                S_EXEC: begin
                    addr_q   <= ex_res;
                    wb_q     <= ex_res;
                    dst_q    <= ex_dst;
                    wb_ram_q <= 1'b0;
                    case (ex_kind)
                        K_ALU: state_q <= S_WB;
                        K_LOAD, K_STORE: begin
                            fl_addr_q <= ex_res[21:0];
                            state_q   <= S_MEM;
                        end
                        K_JUMP: begin
                            if (ex_link && ex_dst != 5'd0) gpr_q[ex_dst] <= ex_res;
                            pc_q      <= npc_q;
                            npc_q     <= ex_taken ? ex_tgt : npc_q + 32'd4;
                            fl_addr_q <= npc_q[21:0];
                            state_q   <= S_FETCH;
                        end
                        default: state_q <= S_HALT;
                    endcase
                end
                S_MEM: begin
                    if (!is_store && mem_flash) begin
                        // flash loads reuse the fetch byte sequencer, shifting into wb_q
                        if (fl_last) begin
                            wait_q <= '0;
                            wb_q   <= {wb_q[23:0], FL_DQ};
                            if (byte_q == 2'd3) begin
                                byte_q  <= '0;
                                state_q <= S_WB;
                            end else begin
                                byte_q    <= byte_q + 2'd1;
                                fl_addr_q <= fl_addr_q + 22'd1;
                            end
                        end else begin
                            wait_q <= wait_q + WW'(1);
                        end
                    end else if (!is_store) begin
                        wb_q     <= io_rd;
                        wb_ram_q <= mem_ram;
                        state_q  <= S_WB;
                    end else begin
                        if (mem_dbg) debug_q <= rt_v;
                        pc_q      <= npc_q;
                        npc_q     <= npc_q + 32'd4;
                        fl_addr_q <= npc_q[21:0];
                        state_q   <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (dst_q != 5'd0) gpr_q[dst_q] <= wb_ram_q ? ram_rd_q : wb_q;
                    pc_q      <= npc_q;
                    npc_q     <= npc_q + 32'd4;
                    fl_addr_q <= npc_q[21:0];
                    state_q   <= S_FETCH;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    assign LEDG = {7'd0, state_q == S_HALT, state_q != S_HALT};
    assign LEDR = debug_q[17:0];

`ifdef MIPS_HEX_DISPLAY_EN
    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        case (d)
            4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;  4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;  4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h10;  4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;  4'hE: hex_seg = 7'h06;  default: hex_seg = 7'h0E;
        endcase
    endfunction
    assign HEX0 = hex_seg(debug_q[3:0]);
    assign HEX1 = hex_seg(debug_q[7:4]);
    assign HEX2 = hex_seg(debug_q[11:8]);
    assign HEX3 = hex_seg(debug_q[15:12]);
    assign HEX4 = hex_seg(debug_q[19:16]);
    assign HEX5 = hex_seg(debug_q[23:20]);
    assign HEX6 = hex_seg(debug_q[27:24]);
    assign HEX7 = hex_seg(debug_q[31:28]);
`else
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;
    assign HEX6 = 7'h7F;
    assign HEX7 = 7'h7F;
`endif

    assign FL_ADDR    = fl_addr_q;
    assign FL_CE_N    = 1'b0;
    assign FL_OE_N    = 1'b0;
    assign FL_WE_N    = 1'b1;
    assign FL_RST_N   = 1'b1;
    assign DRAM_ADDR  = '0;
    assign DRAM_BA_0  = 1'b0;
    assign DRAM_BA_1  = 1'b0;
    assign DRAM_CS_N  = 1'b1;
    assign DRAM_RAS_N = 1'b1;
    assign DRAM_CAS_N = 1'b1;
    assign DRAM_WE_N  = 1'b1;
    assign DRAM_CKE   = 1'b0;
    assign DRAM_CLK   = 1'b0;
    assign DRAM_LDQM  = 1'b0;
    assign DRAM_UDQM  = 1'b0;
    assign DRAM_DQ    = 16'bz;
    assign SRAM_ADDR  = '0;
    assign SRAM_DQ    = 16'bz;
    assign SRAM_UB_N  = 1'b1;
    assign SRAM_LB_N  = 1'b1;
    assign SRAM_WE_N  = 1'b1;
    assign SRAM_OE_N  = 1'b1;
    assign SRAM_CE_N  = 1'b1;

    assign unused_ok = &{1'b0, KEY[3:1], addr_q[1:0]};
endmodule

// File: tb/tb_mips_cpu_top.sv
// Directed bench for mips_cpu_top: small programs in a byte-wide flash model, results observed on LEDR/LEDG/FL_ADDR.
module tb_mips_cpu_top;
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic [3:0]  key;
  logic [17:0] sw;
  wire  [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  wire  [8:0]  ledg;
  wire  [17:0] ledr;
  wire  [11:0] dram_addr;
  wire         dram_ba_0, dram_ba_1, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
  wire         dram_cke, dram_clk, dram_ldqm, dram_udqm;
  wire  [15:0] dram_dq, sram_dq;
  wire  [21:0] fl_addr;
  wire  [7:0]  fl_dq;
  wire         fl_ce_n, fl_oe_n, fl_we_n, fl_rst_n;
  wire  [17:0] sram_addr;
  wire         sram_ub_n, sram_lb_n, sram_we_n, sram_oe_n, sram_ce_n;

  logic [7:0] fmem [256];
  assign fl_dq = fmem[fl_addr[7:0]];

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  mips_cpu_top dut (
    .CLOCK_50(clk), .KEY(key), .SW(sw),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
    .HEX4(hex4), .HEX5(hex5), .HEX6(hex6), .HEX7(hex7),
    .LEDG(ledg), .LEDR(ledr),
    .DRAM_ADDR(dram_addr), .DRAM_BA_0(dram_ba_0), .DRAM_BA_1(dram_ba_1),
    .DRAM_CS_N(dram_cs_n), .DRAM_RAS_N(dram_ras_n), .DRAM_CAS_N(dram_cas_n), .DRAM_WE_N(dram_we_n),
    .DRAM_CKE(dram_cke), .DRAM_CLK(dram_clk), .DRAM_LDQM(dram_ldqm), .DRAM_UDQM(dram_udqm),
    .DRAM_DQ(dram_dq),
    .FL_ADDR(fl_addr), .FL_DQ(fl_dq), .FL_CE_N(fl_ce_n), .FL_OE_N(fl_oe_n),
    .FL_WE_N(fl_we_n), .FL_RST_N(fl_rst_n),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
    .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n), .SRAM_CE_N(sram_ce_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    fmem[addr]     = w[31:24];
    fmem[addr + 1] = w[23:16];
    fmem[addr + 2] = w[15:8];
    fmem[addr + 3] = w[7:0];
  endtask

  task automatic clear_flash();
    for (int i = 0; i < 256; i += 4) put_word(i, 32'hFC00_0000);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    key[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ledg", {23'd0, ledg}, 32'h001);
    check("rst_fl_addr", {10'd0, fl_addr}, 32'd0);
    check("rst_ledr", {14'd0, ledr}, 32'd0);
    key[0] = 1'b1;
  endtask

  task automatic wait_ledr_change(input int budget, output logic [17:0] v, output bit ok);
    logic [17:0] prev;
    prev = ledr;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ledr !== prev) begin
        ok = 1'b1;
        break;
      end
    end
    v = ledr;
  endtask

  task automatic drain(input string tag);
    logic [17:0] e, v;
    bit ok;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_ledr_change(2000, v, ok);
      check({tag, "_timeout"}, {31'd0, ok}, 32'd1);
      check(tag, {14'd0, v}, {14'd0, e});
      if (!ok) exp_q.delete();
    end
  endtask

  task automatic wait_halt(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ledg === 9'h002) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    key = 4'b1110;
    sw  = 18'h2ABCD;
    clear_flash();

    // Program A: debug store with exact cycle timing, then halt
    put_word(0,  32'h3C01_FFFF);  // lui   $1,0xFFFF
    put_word(4,  32'h2402_1234);  // addiu $2,$0,0x1234
    put_word(8,  32'hAC22_0000);  // sw    $2,0($1)
    put_word(12, 32'hFC00_0000);  // opcode 0x3F
    reset_dut();
    repeat (3) @(negedge clk);
    check("fl_addr_hold", {10'd0, fl_addr}, 32'd0);
    @(negedge clk);
    check("fl_addr_step", {10'd0, fl_addr}, 32'd1);
    repeat (49) @(negedge clk);
    check("dbg_before_mem", {14'd0, ledr}, 32'd0);
    @(negedge clk);
    check("dbg_at_mem", {14'd0, ledr}, 32'h01234);
`ifdef MIPS_HEX_DISPLAY_EN
    check("hex0", {25'd0, hex0}, 32'h19);
    check("hex1", {25'd0, hex1}, 32'h30);
    check("hex2", {25'd0, hex2}, 32'h24);
    check("hex3", {25'd0, hex3}, 32'h79);
`else
    check("hex0_off", {25'd0, hex0}, 32'h7F);
    check("hex7_off", {25'd0, hex7}, 32'h7F);
`endif
    repeat (16) @(negedge clk);
    check("ledg_running", {23'd0, ledg}, 32'h001);
    @(negedge clk);
    check("ledg_halt", {23'd0, ledg}, 32'h002);
    check("halt_fl_addr", {10'd0, fl_addr}, 32'd15);
    repeat (20) @(negedge clk);
    check("halt_stays", {23'd0, ledg}, 32'h002);
    check("halt_fl_stable", {10'd0, fl_addr}, 32'd15);

    // Same program, reset asserted while the store sits in MEM: debug must stay 0
    reset_dut();
    repeat (53) @(negedge clk);
    key[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_store", {14'd0, ledr}, 32'd0);
    check("abort_ledg", {23'd0, ledg}, 32'h001);

    // Program B: RAM store then load through a wrapped address
    clear_flash();
    put_word(0,  32'h3C03_1000);  // lui   $3,0x1000
    put_word(4,  32'h2402_1234);  // addiu $2,$0,0x1234
    put_word(8,  32'hAC62_0008);  // sw    $2,8($3)
    put_word(12, 32'h8C64_1008);  // lw    $4,0x1008($3)
    put_word(16, 32'h3C01_FFFF);  // lui   $1,0xFFFF
    put_word(20, 32'hAC24_0000);  // sw    $4,0($1)
    reset_dut();
    exp_q.push_back(18'h01234);
    drain("ram_rt");
    wait_halt("ram_halt");

    // Program C: flash load, SW read, debug readback
    clear_flash();
    put_word(0,  32'h3C01_FFFF);  // lui   $1,0xFFFF
    put_word(4,  32'h8C05_0000);  // lw    $5,0($0)
    put_word(8,  32'h0005_3382);  // srl   $6,$5,14
    put_word(12, 32'hAC26_0000);  // sw    $6,0($1)
    put_word(16, 32'h8C27_0004);  // lw    $7,4($1)
    put_word(20, 32'hAC27_0000);  // sw    $7,0($1)
    put_word(24, 32'h8C28_0000);  // lw    $8,0($1)
    put_word(28, 32'h2508_0001);  // addiu $8,$8,1
    put_word(32, 32'hAC28_0000);  // sw    $8,0($1)
    reset_dut();
    exp_q.push_back(18'h0F007);
    exp_q.push_back(18'h2ABCD);
    exp_q.push_back(18'h2ABCE);
    drain("io_ld");
    wait_halt("io_halt");

    // Program D: beq/jal/jr with delay slots
    clear_flash();
    put_word(0,  32'h3C01_FFFF);  // lui   $1,0xFFFF
    put_word(4,  32'h1000_0002);  // beq   $0,$0,+2
    put_word(8,  32'h2405_0007);  // addiu $5,$0,7 (delay slot)
    put_word(12, 32'h2405_0009);  // addiu $5,$0,9 (skipped)
    put_word(16, 32'hAC25_0000);  // sw    $5,0($1)
    put_word(20, 32'h0C00_000A);  // jal   40
    put_word(24, 32'h0000_0000);  // nop
    put_word(28, 32'hAC25_0000);  // sw    $5,0($1)
    put_word(40, 32'hAC3F_0000);  // sw    $31,0($1)
    put_word(44, 32'h03E0_0008);  // jr    $31
    put_word(48, 32'h2405_000B);  // addiu $5,$0,11 (delay slot)
    reset_dut();
    exp_q.push_back(18'h00007);
    exp_q.push_back(18'h0001C);
    exp_q.push_back(18'h0000B);
    drain("branch");
    wait_halt("branch_halt");

    // Program E: sra sign fill and sltu
    clear_flash();
    put_word(0,  32'h3C01_FFFF);  // lui   $1,0xFFFF
    put_word(4,  32'h2406_FFFF);  // addiu $6,$0,-1
    put_word(8,  32'h0006_3903);  // sra   $7,$6,4
    put_word(12, 32'h0006_402B);  // sltu  $8,$0,$6
    put_word(16, 32'h0007_4C02);  // srl   $9,$7,16
    put_word(20, 32'hAC29_0000);  // sw    $9,0($1)
    put_word(24, 32'hAC28_0000);  // sw    $8,0($1)
    put_word(28, 32'hAC27_0000);  // sw    $7,0($1)
    reset_dut();
    exp_q.push_back(18'h0FFFF);
    exp_q.push_back(18'h00001);
    exp_q.push_back(18'h3FFFF);
    drain("shift");
    wait_halt("shift_halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  wire unused_ok = ^{hex1, hex2, hex3, hex4, hex5, hex6, hex7, dram_addr, dram_ba_0, dram_ba_1,
                     dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_cke, dram_clk, dram_ldqm,
                     dram_udqm, dram_dq, sram_dq, fl_ce_n, fl_oe_n, fl_we_n, fl_rst_n, sram_addr,
                     sram_ub_n, sram_lb_n, sram_we_n, sram_oe_n, sram_ce_n, fl_addr[21:8], key[3:1]};
endmodule

// File: doc/mips_cpu_top.md
# mips_cpu_top

Board-level top of the single-clock multicycle MIPS-I subset processor (`mips_cpu`). It fetches big-endian instructions byte-by-byte from the 8-bit parallel flash and keeps data in on-chip RAM. Results are exposed through a memory-mapped debug register shown on the LEDs and seven-segment displays. SDRAM and SRAM pins are driven idle so board models such as `mt48lc4m16a2` can stay attached without traffic.

## Interface
- `FL_WAIT`, default 4: clock cycles each flash byte address is held before data is captured (≥1).
- `DMEM_WORDS`, default 1024: 32-bit words of on-chip data RAM (power of two).
- `CLOCK_50` in 1: the only clock; all state changes on its rising edge.
- `KEY` in 4: `KEY[0]` is the reset (asynchronous, active-low). `KEY[3:1]` are unused.
- `SW` in 18: readable at address 0xFFFF_0004, zero-extended.
- `HEX7`..`HEX0` out 7 each: active-low segments `{g,f,e,d,c,b,a}`.
- `LEDG` out 9: `[0]` running, `[1]` halted, `[8:2]` = 0.
- `LEDR` out 18: `debug[17:0]`.
- `DRAM_ADDR` out 12, `DRAM_BA_0`/`DRAM_BA_1` out 1: driven 0.
- `DRAM_CS_N`, `DRAM_RAS_N`, `DRAM_CAS_N`, `DRAM_WE_N` out 1: driven 1.
- `DRAM_CKE`, `DRAM_CLK`, `DRAM_LDQM`, `DRAM_UDQM` out 1: driven 0.
- `DRAM_DQ` inout 16: always high-Z.
- `FL_ADDR` out 22: flash byte address.
- `FL_DQ` inout 8: never driven; read only.
- `FL_CE_N`, `FL_OE_N` out 1: driven 0.
- `FL_WE_N`, `FL_RST_N` out 1: driven 1.
- `SRAM_ADDR` out 18: driven 0.
- `SRAM_DQ` inout 16: high-Z.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N` out 1: driven 1.

## Operation
- **Reset state:**
  - PC = 0 and NPC = 4.
  - All 32 GPRs = 0 and debug = 0.
  - `FL_ADDR` = 0 and state = FETCH.
  - `LEDG` = 9'b000000001.
- **State machine:**
  - FETCH → EXEC.
  - EXEC → MEM for loads and stores.
  - EXEC → WB for register-writing instructions.
  - EXEC → FETCH for branches, jumps and `jr`.
  - MEM → WB for loads; MEM → FETCH for stores.
  - WB → FETCH.
  - Any undefined opcode or funct, including `break`, → HALT. HALT is terminal until reset.
- **FETCH:** reads four bytes at PC, PC+1, PC+2, PC+3 into IR, big-endian (byte 0 → IR[31:24]).
- **Supported instructions:**
  - R-type: `addu` `subu` `and` `or` `xor` `nor` `slt` `sltu` `sll` `srl` `sra` `sllv` `srlv` `srav` `jr` `jalr`.
  - I-type: `addiu` `slti` `sltiu` `andi` `ori` `xori` `lui` `lw` `sw` `beq` `bne` `blez` `bgtz`.
  - J-type: `j` `jal`.
- **Arithmetic rules:**
  - All arithmetic is modulo 2^32; there are no overflow traps.
  - The immediate is sign-extended, except for `andi`/`ori`/`xori`, which zero-extend.
  - `lui` places the immediate in bits [31:16] and zeros the low half.
  - Shifts use `shamt` (or `rs[4:0]` for the variable forms); `sra` replicates bit 31.
  - Writes to $0 are discarded and $0 always reads 0.
- **Branch delay slot (implemented):**
  - Each instruction commits PC←NPC. NPC←NPC+4 by default, or NPC←target for a taken branch or jump.
  - The branch target is (address of delay slot) + (sign-extended imm<<2).
  - The `j`/`jal` target is {NPC[31:28], imm26, 2'b00}.
  - `jal`/`jalr` write the return address PC+8 to $31 or `rd`.
- **Memory map (address bits [1:0] ignored):**
  - [31:28] = 0: flash. Loads read four bytes; stores are ignored.
  - [31:28] = 1: RAM word `addr[log2(DMEM_WORDS)+1:2]`, wrapping within the RAM.
  - 0xFFFF_0000: debug register, read/write.
  - 0xFFFF_0004: `SW`, read-only.
  - All other addresses read 0 and ignore writes.

## Timing
- Each flash byte holds `FL_ADDR` for `FL_WAIT` cycles; `FL_DQ` is sampled on the last of those cycles.
- FETCH takes 4·`FL_WAIT` cycles (16 at default). EXEC, RAM/IO MEM and WB take 1 cycle each.
- Instruction cost at default `FL_WAIT`:
  - ALU instructions: 18 cycles.
  - Branches and jumps: 17 cycles.
  - RAM/IO stores: 18 cycles. RAM/IO loads: 19 cycles.
  - Flash loads: 34 cycles, because their MEM phase lasts 4·`FL_WAIT` cycles.
- RAM reads are synchronous, with 1-cycle latency. RAM writes take effect at the MEM edge.
- Debug register: updates at the MEM edge of the store; `LEDR` and `HEX` follow combinationally.
- Reset asserted mid-instruction aborts the instruction immediately, with no partial GPR or RAM write after the assertion.

## Configuration
- `MIPS_HEX_DISPLAY_EN`:
  - Defined: `HEX7`..`HEX0` show debug[31:0] as 8 hex digits, with `HEX0` as the least significant digit.
  - Undefined: every `HEX` output = 7'h7F (all segments off) and the decoder logic is omitted.

## Test plan
- Hold `KEY[0]` low, then release → `FL_ADDR` = 0, `LEDG` = 9'h001, and the first byte address change occurs 4 cycles after release.
- Program `lui $1,0xFFFF` ; `addiu $2,$0,0x1234` ; `sw $2,0($1)` → `LEDR` = 18'h01234; with `MIPS_HEX_DISPLAY_EN`, `HEX3`..`HEX0` show 1,2,3,4.
- `lui $3,0x1000` ; `sw $2,8($3)` ; `lw $4,8($3)` ; store $4 to debug → debug = 0x1234.
- `beq $0,$0,+2` with `addiu $5,$0,7` in the delay slot, then store $5 to debug at the target → debug = 7 and the skipped instruction does not execute.
- `addiu $6,$0,-1` ; `sra $7,$6,4` ; `sltu $8,$0,$6` → $7 = 0xFFFF_FFFF and $8 = 1.
- Opcode 0x3F → `LEDG` = 9'h002, PC frozen and `FL_ADDR` stable; reset recovers execution to PC 0.
